// File: rtl/vfpu_engine_pkg.sv
// Shared types for the SIMD arithmetic engine: lane opcodes and the job
// control word sampled on start.
package vfpu_package;

  localparam int unsigned VFPU_LEN_WIDTH = 16;

  typedef enum logic [1:0] {
    VFPU_ADD = 2'd0,
    VFPU_SUB = 2'd1,
    VFPU_MIN = 2'd2,
    VFPU_MAX = 2'd3
  } vfpu_op_e;

  typedef struct packed {
    vfpu_op_e                  operation;
    logic [VFPU_LEN_WIDTH-1:0] len;
  } vfpu_ctrl_t;

endpackage

// File: rtl/vfpu_engine_if.sv
// Valid/ready stream with byte strobes; source drives the payload, sink
// returns ready.
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 64
) ();

  logic                    valid;
  logic                    ready;
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] strb;

  modport source (output valid, data, strb, input ready);
  modport sink   (input valid, data, strb, output ready);

endinterface

// File: rtl/vfpu_engine_lane.sv
// One SIMD lane ALU: wrapping add/sub and signed min/max, purely combinational.
module vfpu_lane
  import vfpu_package::*;
#(
  parameter int unsigned LANE_WIDTH = 32
) (
  input  vfpu_op_e              op_i,
  input  logic [LANE_WIDTH-1:0] a_i,
  input  logic [LANE_WIDTH-1:0] b_i,
  output logic [LANE_WIDTH-1:0] res_o
);

  logic a_lt_b;

  always_comb begin
    a_lt_b = $signed(a_i) < $signed(b_i);
    res_o  = '0;
    case (op_i)
      VFPU_ADD: res_o = a_i + b_i;
      VFPU_SUB: res_o = a_i - b_i;
      VFPU_MIN: res_o = a_lt_b ? a_i : b_i;
      default:  res_o = a_lt_b ? b_i : a_i;
    endcase
  end

endmodule

// File: rtl/vfpu_engine.sv
// Two-stage elastic SIMD engine: joins operand streams A and B, computes per-lane
// results and counts accepted operands and emitted results against the job length.
module vfpu_engine
  import vfpu_package::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned LANE_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = VFPU_LEN_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  vfpu_ctrl_t            ctrl_i,
  hwpe_stream_intf_stream.sink   a_i,
  hwpe_stream_intf_stream.sink   b_i,
  hwpe_stream_intf_stream.source r_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int NUM_LANES  = int'(DATA_WIDTH / LANE_WIDTH);
  localparam int STRB_WIDTH = int'(DATA_WIDTH / 8);
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]            state_q, state_d;
  vfpu_op_e              op_q, op_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  in_cnt_q, in_cnt_d;
  logic [LEN_WIDTH-1:0]  out_cnt_q, out_cnt_d;
  logic                  done_q, done_d;
  logic                  s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [STRB_WIDTH-1:0] s1_strb_q, s1_strb_d;
  logic                  s2_valid_q, s2_valid_d;
  logic [DATA_WIDTH-1:0] s2_data_q, s2_data_d;
  logic [STRB_WIDTH-1:0] s2_strb_q, s2_strb_d;
  logic [DATA_WIDTH-1:0] lane_res;
  logic                  s1_free, s2_free, accept, in_fire, s1_move, out_fire;

  // A stage may load when empty or when it is draining in the same cycle.
  assign s2_free  = ~s2_valid_q | r_o.ready;
  assign s1_free  = ~s1_valid_q | s2_free;
  assign accept   = (state_q == ST_RUN) & (in_cnt_q < len_q) & s1_free;
  assign a_i.ready = b_i.valid & accept;
  assign b_i.ready = a_i.valid & accept;
  assign in_fire  = a_i.valid & b_i.valid & accept;
  assign s1_move  = s1_valid_q & s2_free;
  assign out_fire = s2_valid_q & r_o.ready;

  assign r_o.valid = s2_valid_q;
  assign r_o.data  = s2_data_q;
  assign r_o.strb  = s2_strb_q;
  assign busy_o    = (state_q == ST_RUN);
  assign done_o    = done_q;

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    vfpu_lane #(.LANE_WIDTH(LANE_WIDTH)) u_lane (
      .op_i  (op_q),
      .a_i   (s1_a_q[gi*LANE_WIDTH +: LANE_WIDTH]),
      .b_i   (s1_b_q[gi*LANE_WIDTH +: LANE_WIDTH]),
      .res_o (lane_res[gi*LANE_WIDTH +: LANE_WIDTH])
    );
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    len_d      = len_q;
    in_cnt_d   = in_cnt_q;
    out_cnt_d  = out_cnt_q;
    done_d     = 1'b0;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_strb_d  = s1_strb_q;
    s2_data_d  = s2_data_q;
    s2_strb_d  = s2_strb_q;
    s1_valid_d = in_fire | (s1_valid_q & ~s2_free);
    s2_valid_d = s1_move | (s2_valid_q & ~r_o.ready);

    if (in_fire) begin
      s1_a_d    = a_i.data;
      s1_b_d    = b_i.data;
      s1_strb_d = a_i.strb & b_i.strb;
      in_cnt_d  = in_cnt_q + LEN_WIDTH'(1);
    end
    if (s1_move) begin
      s2_data_d = lane_res;
      s2_strb_d = s1_strb_q;
    end
    if (out_fire) begin
      out_cnt_d = out_cnt_q + LEN_WIDTH'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          op_d      = ctrl_i.operation;
          len_d     = LEN_WIDTH'(ctrl_i.len);
          in_cnt_d  = '0;
          out_cnt_d = '0;
          if (ctrl_i.len == '0) done_d = 1'b1;
          else                  state_d = ST_RUN;
        end
      end
      default: begin
        if (out_fire && (out_cnt_q + LEN_WIDTH'(1) == len_q)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
    endcase

    if (clear_i) begin
      state_d    = ST_IDLE;
      in_cnt_d   = '0;
      out_cnt_d  = '0;
      done_d     = 1'b0;
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      op_q       <= VFPU_ADD;
      len_q      <= '0;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      done_q     <= 1'b0;
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_strb_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_strb_q  <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      len_q      <= len_d;
      in_cnt_q   <= in_cnt_d;
      out_cnt_q  <= out_cnt_d;
      done_q     <= done_d;
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_strb_q  <= s1_strb_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_strb_q  <= s2_strb_d;
    end
  end

endmodule

// File: tb/tb_vfpu_engine.sv
// Bench for vfpu_engine: directed and randomized jobs checked against a
// lane-by-lane arithmetic reference model and an expected-result queue.
module tb_vfpu_engine;
  import vfpu_package::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       start = 1'b0;
  vfpu_ctrl_t ctrl;
  logic       busy, done;

  hwpe_stream_intf_stream #(.DATA_WIDTH(64)) a_if ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(64)) b_if ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(64)) r_if ();

  vfpu_engine #(.DATA_WIDTH(64), .LANE_WIDTH(32), .LEN_WIDTH(16)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clear_i (clear),
    .start_i (start),
    .ctrl_i  (ctrl),
    .a_i     (a_if),
    .b_i     (b_if),
    .r_o     (r_if),
    .busy_o  (busy),
    .done_o  (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        s_afire, s_bfire, s_rfire, s_rvalid, s_rready, s_done, s_busy, s_aready, s_bready;
  logic [63:0] s_rdata;
  logic [7:0]  s_rstrb;
  logic [63:0] last_out;
  logic [7:0]  last_strb;
  logic [63:0] opa[$], opb[$];
  logic [7:0]  sta[$], stb[$];
  logic [71:0] expq[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Sample on the falling edge (inputs already settled), then step past the next rising edge.
  task automatic tick();
    @(negedge clk);
    s_aready = a_if.ready;
    s_bready = b_if.ready;
    s_afire  = a_if.valid & a_if.ready;
    s_bfire  = b_if.valid & b_if.ready;
    s_rvalid = r_if.valid;
    s_rready = r_if.ready;
    s_rfire  = r_if.valid & r_if.ready;
    s_rdata  = r_if.data;
    s_rstrb  = r_if.strb;
    s_done   = done;
    s_busy   = busy;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model(input int op, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    r = '0;
    for (int l = 0; l < 2; l++) begin
      int     sa;
      int     sb;
      longint x;
      sa = int'(a[l*32 +: 32]);
      sb = int'(b[l*32 +: 32]);
      case (op)
        0:       x = longint'(sa) + longint'(sb);
        1:       x = longint'(sa) - longint'(sb);
        2:       x = (sa < sb) ? longint'(sa) : longint'(sb);
        default: x = (sa > sb) ? longint'(sa) : longint'(sb);
      endcase
      r[l*32 +: 32] = x[31:0];
    end
    return r;
  endfunction

  task automatic clear_ops();
    opa.delete(); opb.delete(); sta.delete(); stb.delete();
  endtask

  task automatic fill_random(input int n);
    clear_ops();
    for (int i = 0; i < n; i++) begin
      opa.push_back({$urandom(), $urandom()});
      opb.push_back({$urandom(), $urandom()});
      sta.push_back(8'($urandom_range(255)));
      stb.push_back(8'($urandom_range(255)));
    end
  endtask

  task automatic run_job(input int op, input int len, input int vprob, input int rprob,
                         input int stall_at, input int skew, input int restart_at);
    int          ia, nout, ndone, first_fire, first_valid, last_hs, done_at;
    logic        a_on, b_on, prev_stall;
    logic [63:0] prev_data;
    ia = 0; nout = 0; ndone = 0; first_fire = -1; first_valid = -1; last_hs = -1; done_at = -1;
    a_on = 1'b0; b_on = 1'b0; prev_stall = 1'b0; prev_data = '0;
    expq.delete();
    ctrl.operation = vfpu_op_e'(op[1:0]);
    ctrl.len       = 16'(len);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (!a_on && $urandom_range(99) < vprob) a_on = 1'b1;
      if (!b_on && k >= skew && $urandom_range(99) < vprob) b_on = 1'b1;
      a_if.valid = a_on;
      b_if.valid = b_on;
      a_if.data  = (ia < len) ? opa[ia] : {$urandom(), $urandom()};
      b_if.data  = (ia < len) ? opb[ia] : {$urandom(), $urandom()};
      a_if.strb  = (ia < len) ? sta[ia] : 8'hFF;
      b_if.strb  = (ia < len) ? stb[ia] : 8'hFF;
      r_if.ready = (k >= stall_at && k < stall_at + 5) ? 1'b0 : ($urandom_range(99) < rprob);
      if (k == restart_at) begin
        start = 1'b1;
        ctrl.operation = vfpu_op_e'(2'(op + 1));
        ctrl.len = 16'd2;
      end
      tick();
      start = 1'b0;
      if (k == 0) chk("busy_after_start", s_busy, len > 0);
      chk("join_fire", s_afire, s_bfire);
      if (!b_on) chk("a_ready_waits_b", s_aready, 0);
      if (ia >= len) chk("ready_after_len", s_aready | s_bready, 0);
      if (prev_stall) begin
        chk("hold_valid", s_rvalid, 1);
        chk("hold_data", s_rdata, prev_data);
      end
      prev_stall = s_rvalid & ~s_rready;
      prev_data  = s_rdata;
      if (s_afire) begin
        if (first_fire < 0) first_fire = k;
        expq.push_back({sta[ia] & stb[ia], model(op, opa[ia], opb[ia])});
        ia++;
        a_on = 1'b0;
        b_on = 1'b0;
      end
      if (s_rvalid && first_valid < 0) begin
        first_valid = k;
        chk("latency", k - first_fire, 2);
      end
      if (s_rfire) begin
        if (expq.size() > 0) begin
          chk("out_data", s_rdata, expq[0][63:0]);
          chk("out_strb", 64'(s_rstrb), 64'(expq[0][71:64]));
          void'(expq.pop_front());
        end else begin
          chk("out_unexpected", 1, 0);
        end
        last_out  = s_rdata;
        last_strb = s_rstrb;
        nout++;
        last_hs = k;
      end
      chk("inflight_le2", (ia - nout) <= 2, 1);
      if (s_done) begin
        ndone++;
        chk("done_after_last_hs", k, last_hs + 1);
        chk("busy_at_done", s_busy, 0);
        done_at = k;
      end
      if (done_at >= 0 && k >= done_at + 3) break;
    end
    chk("out_count", nout, len);
    chk("done_count", ndone, 1);
    chk("queue_empty", expq.size(), 0);
    a_if.valid = 1'b0;
    b_if.valid = 1'b0;
    r_if.ready = 1'b1;
  endtask

  task automatic one_op(input string tag, input int op, input logic [63:0] a, input logic [63:0] b,
                        input logic [7:0] sa, input logic [7:0] sb,
                        input logic [63:0] exp, input logic [7:0] exps);
    clear_ops();
    opa.push_back(a); opb.push_back(b); sta.push_back(sa); stb.push_back(sb);
    run_job(op, 1, 100, 100, -100, 0, -1);
    chk(tag, last_out, exp);
    chk({tag, "_strb"}, 64'(last_strb), 64'(exps));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    a_if.valid = 1'b0; a_if.data = '0; a_if.strb = '0;
    b_if.valid = 1'b0; b_if.data = '0; b_if.strb = '0;
    r_if.ready = 1'b0;
    ctrl = '0;
    #1;
    chk("rst_r_valid", r_if.valid, 0);
    chk("rst_r_data", r_if.data, 0);
    chk("rst_r_strb", 64'(r_if.strb), 0);
    chk("rst_a_ready", a_if.ready, 0);
    chk("rst_b_ready", b_if.ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    r_if.ready = 1'b1;
    tick();

    one_op("add_wrap", 0, 64'h00000001_FFFFFFFF, 64'h00000001_00000001, 8'hFF, 8'h0F,
           64'h00000002_00000000, 8'h0F);
    one_op("sub", 1, 64'h0, 64'h00000001_00000001, 8'hFF, 8'hFF, 64'hFFFFFFFF_FFFFFFFF, 8'hFF);
    one_op("min", 2, 64'h80000000_00000005, 64'h7FFFFFFF_00000003, 8'hF0, 8'h3C,
           64'h80000000_00000003, 8'h30);
    one_op("max", 3, 64'h80000000_00000005, 64'h7FFFFFFF_00000003, 8'hFF, 8'hFF,
           64'h7FFFFFFF_00000005, 8'hFF);

    clear_ops();
    for (int i = 0; i < 8; i++) begin
      opa.push_back(64'(i)); opb.push_back(64'(10 * i)); sta.push_back(8'hFF); stb.push_back(8'hFF);
    end
    run_job(0, 8, 100, 100, 3, 0, -1);
    chk("stream_last", last_out, 64'd77);

    fill_random(5);
    run_job(int'($urandom_range(3)), 5, 100, 100, -100, 3, -1);

    clear_ops();
    run_job(0, 0, 100, 100, -100, 0, -1);

    fill_random(4);
    run_job(0, 4, 80, 90, -100, 0, 2);

    // Fill both stages under backpressure, then flush.
    fill_random(8);
    ctrl.operation = VFPU_ADD;
    ctrl.len = 16'd8;
    start = 1'b1;
    tick();
    start = 1'b0;
    a_if.valid = 1'b1; b_if.valid = 1'b1; r_if.ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("full_r_valid", s_rvalid, 1);
    chk("full_stall_ready", s_aready, 0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    a_if.valid = 1'b0; b_if.valid = 1'b0; r_if.ready = 1'b1;
    tick();
    chk("clr_r_valid", s_rvalid, 0);
    chk("clr_busy", s_busy, 0);
    chk("clr_done", s_done, 0);
    tick();
    chk("clr_done_later", s_done, 0);

    fill_random(6);
    run_job(2, 6, 100, 100, -100, 0, -1);

    for (int j = 0; j < 6; j++) begin
      int n;
      n = int'($urandom_range(1, 10));
      fill_random(n);
      run_job(int'($urandom_range(3)), n, 60, 70, int'($urandom_range(8)), 0, -1);
    end

    // Asynchronous reset in the middle of a job.
    fill_random(6);
    ctrl.operation = VFPU_SUB;
    ctrl.len = 16'd6;
    start = 1'b1;
    tick();
    start = 1'b0;
    a_if.valid = 1'b1; b_if.valid = 1'b1; r_if.ready = 1'b0;
    a_if.data = 64'h1234; b_if.data = 64'h1; a_if.strb = 8'hFF; b_if.strb = 8'hFF;
    for (int i = 0; i < 3; i++) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_r_valid", r_if.valid, 0);
    chk("arst_r_data", r_if.data, 0);
    chk("arst_r_strb", 64'(r_if.strb), 0);
    chk("arst_a_ready", a_if.ready, 0);
    chk("arst_b_ready", b_if.ready, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    a_if.valid = 1'b0; b_if.valid = 1'b0; r_if.ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    fill_random(3);
    run_job(1, 3, 100, 100, -100, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
